if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit pipeline; producer side of the IF/DF stage buffer.
- Owns the program counter and issues requests to instruction memory over a req/ack handshake.
- Presents a registered pc/instruction pair, plus an active-low bubble marker, to the IF/DF buffer.
- Handles hazard stalls (skid capture) and branch redirects (discard or drain of in-flight fetches).

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
PC_STEP, 2, PC increment per fetched instruction (byte addressing, 16-bit instructions)
NOP_INST, 16'h0000, instruction word driven when the output slot is a bubble

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, synchronous, active-low
stall  input  1  hazard unit: 1 = downstream not accepting; pc_out/inst_out/nop_n must hold
redirect  input  1  branch/jump taken this cycle
redirect_pc  input  16  target PC, valid when redirect=1
imem_req  output  1  instruction memory request
imem_addr  output  16  request address
imem_ack  input  1  single-cycle acknowledge; imem_rdata valid in the same cycle
imem_rdata  input  16  fetched instruction
pc_out  output  16  PC of presented instruction (to IF/DF buffer pc input)
inst_out  output  16  presented instruction (to IF/DF buffer instruction input)
nop_n  output  1  active-low bubble: 0 = slot is a NOP (to IF/DF buffer nop input)

Behaviour:
- Registers:
  - pc: next fetch address.
  - req_addr: address of the outstanding request.
  - skid_pc, skid_inst: one-entry skid buffer.
  - state: IDLE, FETCH, HOLD, DRAIN.
- Reset (rst=0 at posedge, any state):
  - state=IDLE, pc=RESET_PC, pc_out=0, inst_out=NOP_INST, nop_n=0, skid cleared.
  - imem_req=0 during reset and in IDLE.
  - Any outstanding request is abandoned; the memory side is reset by the same rst.
- Handshake rules:
  - imem_req=1 in FETCH and DRAIN only.
  - imem_addr=req_addr, stable from req rise until the ack cycle.
  - Request is retired at the posedge where imem_ack=1.
  - imem_ack while imem_req=0 is ignored.
- IDLE: next cycle → FETCH; req_addr<=pc. First request is issued 1 cycle after rst releases.
- FETCH, per posedge. Priority: redirect > ack > stall.
  - redirect & ack: drop rdata; pc<=redirect_pc; req_addr<=redirect_pc; stay FETCH; output bubble.
  - redirect & !ack: pc<=redirect_pc; → DRAIN; output bubble.
  - ack & !stall:
    - pc_out<=req_addr, inst_out<=imem_rdata, nop_n<=1.
    - pc<=pc+PC_STEP; req_addr<=pc+PC_STEP; stay FETCH.
    - Back-to-back acks give 1 instruction/cycle.
  - ack & stall:
    - skid_pc<=req_addr, skid_inst<=imem_rdata; pc<=pc+PC_STEP.
    - → HOLD; outputs hold.
  - !ack & !stall: pc_out<=req_addr, inst_out<=NOP_INST, nop_n<=0 (bubble).
  - !ack & stall: outputs hold.
- HOLD: imem_req=0.
  - redirect: skid discarded; pc<=redirect_pc, req_addr<=redirect_pc; → FETCH; output bubble.
  - else !stall: pc_out<=skid_pc, inst_out<=skid_inst, nop_n<=1; req_addr<=pc; → FETCH.
  - else: hold.
- DRAIN: waits for the stale request's ack.
  - Further redirect: pc<=latest redirect_pc.
  - On ack: rdata discarded; req_addr<=pc (or the same-cycle redirect_pc); → FETCH.
  - Outputs stay bubble (nop_n=0) for the whole state, even under stall.
- Output bubble:
  - pc_out<=current pc_out, inst_out<=NOP_INST, nop_n<=0.
  - Redirect bubbles override stall: a flushed slot never holds a wrong-path instruction.
- Arithmetic: pc+PC_STEP is modulo 2^16; 16'hFFFE+2 = 16'h0000, no flag.
- Latency: address issued at cycle N with ack at N gives pc_out/inst_out at N+1.
- Invariants:
  - At most one outstanding request.
  - Never more than one skid entry.
  - No instruction is lost or duplicated under stall.

Test Plan:
- Reset then ack every cycle from mem returning addr^16'hA5A5 → pc_out 0000,0002,0004… one per cycle; nop_n=1 from the 2nd cycle after release; first imem_addr=0000.
- Ack at addr 0004 with stall=1 for 3 cycles → outputs frozen on the 0002 instruction; imem_req=0 in HOLD; when stall drops, the 0004 instruction appears next cycle; next imem_addr=0006.
- Redirect to 1230 while 0008 is outstanding with ack delayed 3 cycles → DRAIN; imem_addr held at 0008; 0008 data discarded; nop_n=0 throughout; next imem_addr=1230.
- Redirect to 0400 coincident with ack of 000A under stall=1 → 000A dropped; bubble presented despite stall; next imem_addr=0400.
- RESET_PC=FFFC streaming → addresses FFFC, FFFE, 0000, 0002.
- rst=0 during DRAIN → next cycle imem_req=0, nop_n=0, pc_out=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// presents a registered pc/instruction/bubble triple to the IF/DF buffer.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc_out,
    output logic [15:0] inst_out,
    output logic        nop_n
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [15:0] STEP = 16'(PC_STEP);

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic [15:0] skid_inst_q, skid_inst_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] inst_out_q, inst_out_d;
    logic        nop_n_q, nop_n_d;
    logic [15:0] pc_inc;
    logic        ack;

    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = req_addr_q;
    assign pc_out    = pc_out_q;
    assign inst_out  = inst_out_q;
    assign nop_n     = nop_n_q;

    // Acks arriving while no request is up are ignored; wrap-around is intended.
    assign ack    = imem_ack & imem_req;
    assign pc_inc = pc_q + STEP;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        pc_out_d    = pc_out_q;
        inst_out_d  = inst_out_q;
        nop_n_d     = nop_n_q;

        case (state_q)
            IDLE: begin
                req_addr_d = pc_q;
                state_d    = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // Flushed slot becomes a bubble even under stall.
                    pc_d       = redirect_pc;
                    inst_out_d = NOP_INST;
                    nop_n_d    = 1'b0;
                    if (ack) begin
                        req_addr_d = redirect_pc;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (ack) begin
                    pc_d = pc_inc;
                    if (!stall) begin
                        pc_out_d   = req_addr_q;
                        inst_out_d = imem_rdata;
                        nop_n_d    = 1'b1;
                        req_addr_d = pc_inc;
                    end else begin
                        skid_pc_d   = req_addr_q;
                        skid_inst_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else if (!stall) begin
                    pc_out_d   = req_addr_q;
                    inst_out_d = NOP_INST;
                    nop_n_d    = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    inst_out_d = NOP_INST;
                    nop_n_d    = 1'b0;
                    state_d    = FETCH;
                end else if (!stall) begin
                    pc_out_d   = skid_pc_q;
                    inst_out_d = skid_inst_q;
                    nop_n_d    = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                // DRAIN: wait out the stale request, keep the latest target.
                inst_out_d = NOP_INST;
                nop_n_d    = 1'b0;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (ack) begin
                    req_addr_d = redirect ? redirect_pc : pc_q;
                    state_d    = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            skid_pc_q   <= 16'h0000;
            skid_inst_q <= 16'h0000;
            pc_out_q    <= 16'h0000;
            inst_out_q  <= NOP_INST;
            nop_n_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            pc_out_q    <= pc_out_d;
            inst_out_q  <= inst_out_d;
            nop_n_q     <= nop_n_d;
        end
    end

endmodule
